// File: rtl/dqpsk_frame_ctrl_if.sv
// rtl/dqpsk_frame_ctrl_if.sv - byte stream in, encoder drive out, for dqpsk_frame_ctrl
interface dqpsk_frame_ctrl_if;
  logic [7:0] din;
  logic       din_valid;
  logic       din_last;
  logic       din_ready;
  logic [1:0] ab;
  logic       ab_en;
  logic       enc_clr;
  logic       busy;
  logic       frame_done;
  logic       underrun;

  modport master (
    output din, din_valid, din_last,
    input  din_ready, ab, ab_en, enc_clr, busy, frame_done, underrun
  );

  modport slave (
    input  din, din_valid, din_last,
    output din_ready, ab, ab_en, enc_clr, busy, frame_done, underrun
  );
endinterface

// File: rtl/dqpsk_frame_ctrl.sv
// rtl/dqpsk_frame_ctrl.sv - DQPSK transmit frame sequencer: encoder clear, preamble, MSB-first dibits, underrun fill
module dqpsk_frame_ctrl #(
  parameter int unsigned SYM_DIV    = 16,
  parameter int unsigned PRE_LEN    = 8,
  parameter logic [1:0]  PRE_DIBIT  = 2'b11,
  parameter logic [1:0]  FILL_DIBIT = 2'b00
) (
  input logic              clk,
  input logic              rst,
  dqpsk_frame_ctrl_if.slave io_bus
);
  localparam logic [15:0] SYM_LAST = 16'(SYM_DIV - 1);
  localparam logic [7:0]  PRE_LAST = 8'(PRE_LEN - 1);

  typedef enum logic [2:0] {IDLE, CLR, PRE, DATA, DONE} state_t;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_sym_cnt;
  logic [7:0]  r_pre_cnt;
  logic [1:0]  r_idx;
  logic [7:0]  r_sh, r_buf;
  logic        r_sh_last, r_buf_last, r_buf_full;
  logic [1:0]  r_ab;
  logic        r_ab_en, r_underrun, r_fin;
  logic        w_run, w_tick, w_ready, w_load;
  logic        w_enc_clr, w_busy, w_frame_done;
  logic [1:0]  w_sel;

  // The timer already runs during CLR so the first strobe lands SYM_DIV clocks after enc_clr.
  assign w_run   = (r_state == CLR) || (r_state == PRE) || (r_state == DATA);
  assign w_tick  = w_run && (r_sym_cnt == SYM_LAST);
  assign w_ready = !r_buf_full && ((r_state == PRE) || (r_state == DATA));
  assign w_load  = io_bus.din_valid && w_ready;

  always_comb begin
    w_sel = r_sh[7:6];
    case (r_idx)
      2'd1:    w_sel = r_sh[5:4];
      2'd2:    w_sel = r_sh[3:2];
      2'd3:    w_sel = r_sh[1:0];
      default: w_sel = r_sh[7:6];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_enc_clr    = 1'b0;
    w_busy       = 1'b1;
    w_frame_done = 1'b0;
    case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        if (io_bus.din_valid) w_state_nxt = CLR;
      end
      CLR: begin
        w_enc_clr   = 1'b1;
        w_state_nxt = PRE;
      end
      PRE:  if (w_tick && (r_pre_cnt == PRE_LAST)) w_state_nxt = DATA;
      DATA: if (r_fin) w_state_nxt = DONE;
      DONE: begin
        w_frame_done = 1'b1;
        w_state_nxt  = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  r_sym_cnt <= '0;
    else if (!w_run || w_tick) r_sym_cnt <= '0;
    else                      r_sym_cnt <= r_sym_cnt + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre_cnt  <= '0;
      r_idx      <= '0;
      r_sh       <= '0;
      r_sh_last  <= 1'b0;
      r_buf      <= '0;
      r_buf_last <= 1'b0;
      r_buf_full <= 1'b0;
      r_ab       <= 2'b00;
      r_ab_en    <= 1'b0;
      r_underrun <= 1'b0;
      r_fin      <= 1'b0;
    end else begin
      r_ab_en    <= 1'b0;
      r_underrun <= 1'b0;
      r_fin      <= 1'b0;
      if (w_load) begin
        r_buf      <= io_bus.din;
        r_buf_last <= io_bus.din_last;
        r_buf_full <= 1'b1;
      end
      if (r_state == CLR) begin
        r_pre_cnt <= '0;
        r_idx     <= '0;
      end
      if (w_tick && (r_state == PRE)) begin
        r_ab      <= PRE_DIBIT;
        r_ab_en   <= 1'b1;
        r_pre_cnt <= r_pre_cnt + 8'd1;
      end
      // A byte boundary with nothing buffered sends a fill and keeps idx at 0 to retry next symbol.
      if (w_tick && (r_state == DATA)) begin
        r_ab_en <= 1'b1;
        if (r_idx == 2'd0) begin
          if (r_buf_full) begin
            r_sh       <= r_buf;
            r_sh_last  <= r_buf_last;
            r_buf_full <= 1'b0;
            r_ab       <= r_buf[7:6];
            r_idx      <= 2'd1;
          end else begin
            r_ab       <= FILL_DIBIT;
            r_underrun <= 1'b1;
          end
        end else begin
          r_ab  <= w_sel;
          r_idx <= r_idx + 2'd1;
          if ((r_idx == 2'd3) && r_sh_last) r_fin <= 1'b1;
        end
      end
    end
  end

  assign io_bus.din_ready  = w_ready;
  assign io_bus.ab         = r_ab;
  assign io_bus.ab_en      = r_ab_en;
  assign io_bus.underrun   = r_underrun;
  assign io_bus.enc_clr    = w_enc_clr;
  assign io_bus.busy       = w_busy;
  assign io_bus.frame_done = w_frame_done;
endmodule

// File: tb/tb_dqpsk_frame_ctrl.sv
// tb/tb_dqpsk_frame_ctrl.sv - randomized self-checking bench for dqpsk_frame_ctrl
module tb_dqpsk_frame_ctrl;
  localparam int         D     = 4;
  localparam int         P     = 2;
  localparam logic [1:0] PRE_D = 2'b11;
  localparam logic [1:0] FILL  = 2'b00;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dqpsk_frame_ctrl_if bus ();
  dqpsk_frame_ctrl_if bus2 ();
  dqpsk_frame_ctrl_if bus3 ();

  dqpsk_frame_ctrl #(.SYM_DIV(D), .PRE_LEN(P), .PRE_DIBIT(PRE_D), .FILL_DIBIT(FILL))
    u_dut (.clk(clk), .rst(rst), .io_bus(bus));
  dqpsk_frame_ctrl #(.SYM_DIV(2), .PRE_LEN(1), .PRE_DIBIT(2'b11), .FILL_DIBIT(2'b00))
    u_fast (.clk(clk), .rst(rst), .io_bus(bus2));
  dqpsk_frame_ctrl #(.SYM_DIV(65535), .PRE_LEN(1), .PRE_DIBIT(2'b11), .FILL_DIBIT(2'b00))
    u_slow (.clk(clk), .rst(rst), .io_bus(bus3));

  int         st_cyc[$];
  logic [1:0] st_ab[$];
  logic       st_und[$];
  int         clr_q[$], done_q[$], hs_q[$];
  int         stall = 0;
  int         viol = 0;
  int         exp_cyc[$];
  logic [1:0] exp_ab[$];
  logic       exp_und[$];
  logic [7:0] f_data[$];
  int         f_dly[$];

  always @(negedge clk) begin
    if (bus.ab_en) begin
      st_cyc.push_back(cyc);
      st_ab.push_back(bus.ab);
      st_und.push_back(bus.underrun);
    end
    if (bus.enc_clr) clr_q.push_back(cyc);
    if (bus.frame_done) done_q.push_back(cyc);
    if (bus.din_valid && bus.din_ready) hs_q.push_back(cyc);
    if (bus.din_valid && !bus.din_ready && bus.busy && !bus.enc_clr && !bus.frame_done) stall++;
    if ((bus.ab_en && (bus.enc_clr || bus.frame_done || !bus.busy)) || (bus.underrun && !bus.ab_en)) viol++;
  end

  // Expected strobe schedule: preamble every d clocks after clear, then four MSB-first dibits per
  // byte; a byte boundary whose byte was not handed over at least two cycles earlier becomes a fill.
  function automatic int model(input int d, input int p, input logic [1:0] pre, input int c,
                               input int hs[$], input logic [7:0] dat[$]);
    int s, b, q, guard;
    exp_cyc.delete(); exp_ab.delete(); exp_und.delete();
    s = c;
    for (int j = 0; j < p; j++) begin
      s += d;
      exp_cyc.push_back(s); exp_ab.push_back(pre); exp_und.push_back(1'b0);
    end
    b = 0; q = 0; guard = 0;
    while (b < dat.size() && guard < 4000) begin
      s += d; guard++;
      exp_cyc.push_back(s);
      if (q == 0 && !(b < hs.size() && hs[b] <= s - 2)) begin
        exp_ab.push_back(FILL); exp_und.push_back(1'b1);
      end else begin
        exp_ab.push_back(2'((dat[b] >> (6 - 2 * q)) & 8'h3)); exp_und.push_back(1'b0);
        q++;
        if (q == 4) begin q = 0; b++; end
      end
    end
    return s + 1;
  endfunction

  task automatic clear_logs();
    st_cyc.delete(); st_ab.delete(); st_und.delete();
    clr_q.delete(); done_q.delete(); hs_q.delete();
    stall = 0;
  endtask

  task automatic push_byte(input logic [7:0] d, input logic l);
    int n = 0;
    bus.din = d; bus.din_last = l; bus.din_valid = 1'b1;
    while (bus.din_ready !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    checks++;
    if (n >= 2000) begin errors++; $display("FAIL push_byte: din_ready never seen, byte %h", d); end
    @(posedge clk); #1;
    bus.din_valid = 1'b0;
  endtask

  task automatic run_frame();
    int n = 0;
    clear_logs();
    for (int k = 0; k < f_data.size(); k++) begin
      if (f_dly[k] > 0) begin repeat (f_dly[k]) @(posedge clk); #1; end
      push_byte(f_data[k], 1'(k == f_data.size() - 1));
    end
    while (bus.frame_done !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    checks++;
    if (n >= 3000) begin errors++; $display("FAIL run_frame: frame_done timeout, got 0 want 1"); end
    #1;
  endtask

  task automatic check_frame(input string nm, input bit tail);
    int c, ed, m;
    c = (clr_q.size() > 0) ? clr_q[0] : 0;
    checks++;
    if (clr_q.size() != 1) begin errors++; $display("FAIL %s enc_clr count: got %0d want 1", nm, clr_q.size()); end
    checks++;
    if (hs_q.size() != f_data.size()) begin
      errors++; $display("FAIL %s handshakes: got %0d want %0d", nm, hs_q.size(), f_data.size());
    end
    ed = model(D, P, PRE_D, c, hs_q, f_data);
    checks++;
    if (st_cyc.size() != exp_cyc.size()) begin
      errors++; $display("FAIL %s strobe count: got %0d want %0d", nm, st_cyc.size(), exp_cyc.size());
    end
    m = (st_cyc.size() < exp_cyc.size()) ? st_cyc.size() : exp_cyc.size();
    for (int i = 0; i < m; i++) begin
      checks++;
      if (st_cyc[i] !== exp_cyc[i] || st_ab[i] !== exp_ab[i] || st_und[i] !== exp_und[i]) begin
        errors++;
        $display("FAIL %s strobe %0d: got clr+%0d ab=%b und=%b want clr+%0d ab=%b und=%b", nm, i,
                 st_cyc[i] - c, st_ab[i], st_und[i], exp_cyc[i] - c, exp_ab[i], exp_und[i]);
      end
    end
    checks++;
    if (done_q.size() != 1 || done_q[0] != ed) begin
      errors++;
      $display("FAIL %s frame_done: got n=%0d at clr+%0d want 1 at clr+%0d", nm, done_q.size(),
               (done_q.size() > 0) ? done_q[0] - c : -1, ed - c);
    end
    if (tail) begin
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || bus.ab !== exp_ab[$]) begin
        errors++; $display("FAIL %s after frame: got busy=%b ab=%b want busy=0 ab=%b", nm, bus.busy, bus.ab, exp_ab[$]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.ab, bus.ab_en, bus.enc_clr, bus.busy, bus.frame_done, bus.underrun, bus.din_ready} !== 8'h00) begin
      errors++;
      $display("FAIL reset outputs: got ab=%b en=%b clr=%b busy=%b done=%b und=%b rdy=%b want all 0", bus.ab,
               bus.ab_en, bus.enc_clr, bus.busy, bus.frame_done, bus.underrun, bus.din_ready);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.din_ready !== 1'b0) begin
      errors++; $display("FAIL idle after reset: got busy=%b rdy=%b want 0 0", bus.busy, bus.din_ready);
    end
  endtask

  task automatic test_single();
    f_data = '{8'hB4}; f_dly = '{0};
    run_frame();
    check_frame("single", 1'b1);
  endtask

  task automatic test_underrun();
    int fills = 0;
    f_data = '{8'hFF, 8'h00}; f_dly = '{0, 10 * D};
    run_frame();
    check_frame("underrun", 1'b1);
    foreach (st_und[i]) if (st_und[i]) fills++;
    checks++;
    if (fills < 1) begin errors++; $display("FAIL underrun fills: got %0d want >=1", fills); end
  endtask

  task automatic test_backpressure();
    f_data = '{8'($urandom), 8'($urandom), 8'($urandom)}; f_dly = '{0, 0, 0};
    run_frame();
    check_frame("backpressure", 1'b1);
    checks++;
    if (st_cyc.size() != P + 12) begin errors++; $display("FAIL backpressure strobes: got %0d want %0d", st_cyc.size(), P + 12); end
    checks++;
    if (stall == 0) begin errors++; $display("FAIL backpressure stall cycles: got 0 want >0"); end
  endtask

  task automatic test_back_to_back();
    int prev_done;
    f_data = '{8'($urandom), 8'($urandom)}; f_dly = '{0, 0};
    run_frame();
    check_frame("b2b_first", 1'b0);
    prev_done = (done_q.size() > 0) ? done_q[0] : 0;
    f_data = '{8'($urandom)}; f_dly = '{0};
    run_frame();
    check_frame("b2b_second", 1'b1);
    checks++;
    if (clr_q.size() == 0 || clr_q[0] - prev_done < 2) begin
      errors++; $display("FAIL b2b clear gap: got %0d want >=2", (clr_q.size() > 0) ? clr_q[0] - prev_done : -1);
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 6; f++) begin
      int nb;
      nb = $urandom_range(1, 4);
      f_data.delete(); f_dly.delete();
      for (int k = 0; k < nb; k++) begin
        f_data.push_back(8'($urandom));
        if (k == 0) f_dly.push_back($urandom_range(0, 3));
        else        f_dly.push_back(($urandom_range(0, 3) == 0) ? $urandom_range(4, 40) : 0);
      end
      run_frame();
      check_frame("random", 1'b1);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    clear_logs();
    push_byte(8'h3C, 1'b0);
    push_byte(8'hA5, 1'b0);
    while (st_cyc.size() < P + 2 && n < 500) begin @(negedge clk); n++; end
    checks++;
    if (n >= 500) begin errors++; $display("FAIL reset_mid: strobes got %0d want %0d", st_cyc.size(), P + 2); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.busy, bus.ab_en, bus.enc_clr, bus.frame_done, bus.underrun, bus.din_ready} !== 6'b0 || bus.ab !== 2'b00) begin
      errors++;
      $display("FAIL reset_mid outputs: got busy=%b en=%b clr=%b done=%b und=%b rdy=%b ab=%b want all 0", bus.busy,
               bus.ab_en, bus.enc_clr, bus.frame_done, bus.underrun, bus.din_ready, bus.ab);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (done_q.size() != 0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL reset_mid aftermath: got done=%0d busy=%b want 0 0", done_q.size(), bus.busy);
    end
    f_data = '{8'($urandom), 8'($urandom)}; f_dly = '{0, 0};
    run_frame();
    check_frame("after_reset", 1'b1);
  endtask

  task automatic test_extreme_fast();
    int c = -1, dn = -1, n = 0, ed, m;
    int xc[$], xh[$];
    logic [1:0] xa[$];
    logic xu[$];
    logic [7:0] xd[$];
    xd.push_back(8'h1B);
    bus2.din = 8'h1B; bus2.din_last = 1'b1; bus2.din_valid = 1'b1;
    while (dn < 0 && n < 200) begin
      @(negedge clk); n++;
      if (bus2.din_valid && bus2.din_ready) xh.push_back(cyc);
      else if (xh.size() > 0) bus2.din_valid = 1'b0;
      if (bus2.enc_clr) c = cyc;
      if (bus2.ab_en) begin xc.push_back(cyc); xa.push_back(bus2.ab); xu.push_back(bus2.underrun); end
      if (bus2.frame_done) dn = cyc;
    end
    bus2.din_valid = 1'b0;
    ed = model(2, 1, 2'b11, c, xh, xd);
    checks++;
    if (xc.size() != exp_cyc.size()) begin errors++; $display("FAIL fast strobe count: got %0d want %0d", xc.size(), exp_cyc.size()); end
    m = (xc.size() < exp_cyc.size()) ? xc.size() : exp_cyc.size();
    for (int i = 0; i < m; i++) begin
      checks++;
      if (xc[i] !== exp_cyc[i] || xa[i] !== exp_ab[i] || xu[i] !== exp_und[i]) begin
        errors++;
        $display("FAIL fast strobe %0d: got clr+%0d ab=%b und=%b want clr+%0d ab=%b und=%b", i, xc[i] - c, xa[i],
                 xu[i], exp_cyc[i] - c, exp_ab[i], exp_und[i]);
      end
    end
    checks++;
    if (dn != ed) begin errors++; $display("FAIL fast frame_done: got clr+%0d want clr+%0d", dn - c, ed - c); end
  endtask

  task automatic test_extreme_slow();
    int c = -1, s = -1, n = 0, nh = 0;
    logic [1:0] a = 2'b00;
    logic u = 1'b0;
    bus3.din = 8'h1B; bus3.din_last = 1'b1; bus3.din_valid = 1'b1;
    while (s < 0 && n < 70000) begin
      @(negedge clk); n++;
      if (bus3.din_valid && bus3.din_ready) nh++;
      else if (nh > 0) bus3.din_valid = 1'b0;
      if (bus3.enc_clr) c = cyc;
      if (bus3.ab_en) begin s = cyc; a = bus3.ab; u = bus3.underrun; end
    end
    bus3.din_valid = 1'b0;
    checks++;
    if (s - c != 65535 || c < 0) begin errors++; $display("FAIL slow first strobe: got clr+%0d want clr+65535", s - c); end
    checks++;
    if (a !== 2'b11 || u !== 1'b0 || nh != 1) begin
      errors++; $display("FAIL slow strobe content: got ab=%b und=%b hs=%0d want ab=11 und=0 hs=1", a, u, nh);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_invariants();
    checks++;
    if (viol != 0) begin errors++; $display("FAIL strobe invariants: got %0d violations want 0", viol); end
  endtask

  initial begin
    bus.din = '0;  bus.din_valid = 1'b0;  bus.din_last = 1'b0;
    bus2.din = '0; bus2.din_valid = 1'b0; bus2.din_last = 1'b0;
    bus3.din = '0; bus3.din_valid = 1'b0; bus3.din_last = 1'b0;
    rst = 1'b1;
    test_reset();
    test_single();
    test_underrun();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_extreme_fast();
    test_extreme_slow();
    test_invariants();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
